ssd_scan_mux: RTL and testbench
===============================

// Module: ssd_scan_mux
// PURPOSE
// - Time-multiplexed scanner for the board's common-anode 7-segment bank; sits directly upstream of
//   the hex-to-segment decoder (4-bit nibble in, 7 active-low segments out).
// - Captures a 4*NUM_DIGITS-bit value (e.g. core PC/register debug word), cycles one digit per refresh slot,
//   drives the decoder nibble plus one-hot anode enables; tear-free frame updates, optional leading-zero blanking.
// PARAMETERS
// - NUM_DIGITS   8       digits in bank (2..8)
// - REFRESH_DIV  100000  clk cycles per digit slot (>= GUARD+2)
// - GUARD        16      cycles at start of each slot with all anodes off (anti-ghosting)
// - ANODE_LOW    1       1: anode enable active-low; 0: active-high
// PORTS
// - clk          in   1             system clock, all logic rising-edge
// - rst          in   1             synchronous, active-high reset
// - data_in      in   4*NUM_DIGITS  value to show; nibble 0 = rightmost digit
// - load         in   1             capture data_in into shadow register this cycle
// - blank_lz     in   1             1: blank leading zeros (digit 0 never blanked)
// - digit_x      out  4             nibble for the decoder
// - digit_blank  out  1             1: current digit blanked (anode held inactive)
// - anode        out  NUM_DIGITS    digit enables, polarity per ANODE_LOW
// - digit_idx    out  $clog2(NUM_DIGITS)  index of digit being driven
// - frame_done   out  1             1-cycle pulse on last cycle of digit NUM_DIGITS-1 slot
// BEHAVIOUR
// - Reset (rst=1 at clk edge): prescaler=0, digit_idx=0, shadow=0, display=0, digit_x=0, digit_blank=0,
//   anode=all inactive, frame_done=0. Reset mid-slot/mid-frame aborts immediately; no partial state kept.
// - Prescaler counts 0..REFRESH_DIV-1, wraps to 0. Terminal count (TC) = prescaler==REFRESH_DIV-1.
// - At TC: digit_idx <= (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1. frame_done=1 in the TC cycle of last digit.
// - load=1: shadow <= data_in next edge; back-to-back loads, last one wins.
// - Display register updated only at frame boundary (TC with digit_idx==NUM_DIGITS-1): display <= shadow.
//   Same-cycle load and frame boundary: display <= data_in (bypass), shadow <= data_in.
// - digit_x = display nibble [digit_idx], registered: valid from first cycle of slot (prescaler==0).
// - Leading-zero blank: digit i (i>0) blanked iff blank_lz=1 and display nibbles i..NUM_DIGITS-1 all zero.
//   Value 0 shows a single "0" on digit 0. blank_lz sampled per slot at prescaler==0.
// - anode: all inactive while prescaler < GUARD or digit_blank=1; else only bit digit_idx active.
//   Registered outputs; anode change lags prescaler by exactly 1 cycle.
// - Wrap: prescaler and digit_idx wrap silently; no overflow flags. Unused display bits above NUM_DIGITS ignored.
// STRUCTURE
// - Shared package ssd_pkg: ANODE_ON/ANODE_OFF constants derived from ANODE_LOW, digit-index width function,
//   default REFRESH_DIV for 100 MHz board clock (1 kHz per digit).
// - One sub-module: ssd_tick_gen (prescaler; outputs TC and in_guard). Scan/blank/anode logic in top.
// - Top-level board wrapper instantiates ssd_scan_mux -> decoder; digit_blank does not gate segments.
// TESTING (bench params NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, ANODE_LOW=1)
// - Reset: hold rst 3 cycles, release -> anode=4'b1111, digit_idx=0, digit_x=0, frame_done=0.
// - Scan order: load 16'h1234, wait 1 frame -> per slot digit_x 4,3,2,1 with anode 1110,1101,1011,0111
//   after 2 guard cycles of 1111; frame_done once per 32 cycles.
// - Tear-free: load 16'hABCD mid-frame -> remainder of frame still shows 1234; next frame shows D,C,B,A.
// - Simultaneous: load 16'h00F0 exactly on frame-boundary TC -> very next slot shows digit_x=0 of 00F0.
// - LZ blank: blank_lz=1, value 16'h0050 -> digits 2,3 blanked (anode 1111 all slot), digits 0,1 show 0,5;
//   value 16'h0000 -> only digit 0 lit showing 0.
// - Reset mid-slot: assert rst at prescaler=5 of digit 2 -> next cycle digit_idx=0, anode=1111, display=0.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and helpers for the 7-segment scan path
//
// Purpose : anode polarity helpers, digit-index width function, board-clock
//           refresh defaults and the hex-to-segment table used downstream.
// Ports   : none (package)

package ssd_pkg;

  // 100 MHz board clock / 100000 = 1 kHz per digit slot
  localparam int DEFAULT_REFRESH_DIV = 100000;
  localparam int DEFAULT_GUARD       = 16;

  // Width of a digit index; never narrower than one bit
  function automatic int idx_width(input int num_digits);
    return (num_digits < 2) ? 1 : $clog2(num_digits);
  endfunction

  // Level that turns an anode on for the given polarity setting
  function automatic logic anode_on_level(input int anode_low);
    return (anode_low != 0) ? 1'b0 : 1'b1;
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7f;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b0000011;
      4'hc: seg = 7'b1000110;
      4'hd: seg = 7'b0100001;
      4'he: seg = 7'b0000110;
      4'hf: seg = 7'b0001110;
      default: seg = 7'h7f;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// rtl/ssd_tick_gen.sv - per-digit slot prescaler
//
// Purpose : counts 0..REFRESH_DIV-1 and flags the slot phases.
// Ports   : i_clk         system clock
//           i_rst         synchronous active-high reset
//           o_tc          last cycle of the slot (count == REFRESH_DIV-1)
//           o_slot_start  first cycle of the slot (count == 0)
//           o_in_guard    count < GUARD, anodes must be dark

module ssd_tick_gen
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int GUARD       = DEFAULT_GUARD
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tc,
  output logic o_slot_start,
  output logic o_in_guard
);

  localparam int CW = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (o_tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tc         = (r_count == CW'(REFRESH_DIV - 1));
  assign o_slot_start = (r_count == '0);
  assign o_in_guard   = (r_count < CW'(GUARD));

endmodule

// File: rtl/ssd_scan_mux.sv
// rtl/ssd_scan_mux.sv - time-multiplexed scanner for the common-anode digit bank
//
// Purpose : captures a hex word, shows one nibble per refresh slot with
//           guard-time anode blanking, tear-free frame swaps and optional
//           leading-zero suppression.
// Ports   : i_clk          system clock
//           i_rst          synchronous active-high reset
//           i_data_in      value to show, nibble 0 = rightmost digit
//           i_load         capture i_data_in into the shadow register
//           i_blank_lz     suppress leading zeros (digit 0 always shown)
//           o_digit_x      nibble for the segment decoder
//           o_digit_blank  current digit is suppressed
//           o_anode        digit enables, polarity set by ANODE_LOW
//           o_digit_idx    index of the digit being driven
//           o_frame_done   pulse on the last cycle of the final digit slot

module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int GUARD       = DEFAULT_GUARD,
  parameter int ANODE_LOW   = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [4*NUM_DIGITS-1:0]          i_data_in,
  input  logic                             i_load,
  input  logic                             i_blank_lz,
  output logic [3:0]                       o_digit_x,
  output logic                             o_digit_blank,
  output logic [NUM_DIGITS-1:0]            o_anode,
  output logic [idx_width(NUM_DIGITS)-1:0] o_digit_idx,
  output logic                             o_frame_done
);

  localparam int   IW        = idx_width(NUM_DIGITS);
  localparam int   DW        = 4 * NUM_DIGITS;
  localparam logic ANODE_ON  = anode_on_level(ANODE_LOW);
  localparam logic ANODE_OFF = ~ANODE_ON;

  logic                  w_tc;
  logic                  w_slot_start;
  logic                  w_in_guard;

  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_shadow;
  logic [DW-1:0]         r_display;
  logic [3:0]            r_digit_x;
  logic                  r_digit_blank;
  logic [NUM_DIGITS-1:0] r_anode;

  logic                  w_last_digit;
  logic                  w_frame_end;
  logic [IW-1:0]         w_idx_next;
  logic [DW-1:0]         w_shadow_next;
  logic [DW-1:0]         w_display_next;
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_blank_calc;
  logic                  w_blank_eff;
  logic [NUM_DIGITS-1:0] w_anode_next;

  ssd_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD)
  ) u_tick (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_tc         (w_tc),
    .o_slot_start (w_slot_start),
    .o_in_guard   (w_in_guard)
  );

  assign w_last_digit = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_frame_end  = w_tc && w_last_digit;

  always_comb begin
    w_idx_next = r_idx;
    if (w_tc) begin
      w_idx_next = w_last_digit ? '0 : r_idx + IW'(1);
    end
  end

  // A load landing on the frame boundary goes straight to the display,
  // so the newest value is never held back a whole frame.
  assign w_shadow_next  = i_load ? i_data_in : r_shadow;
  assign w_display_next = w_frame_end ? w_shadow_next : r_display;

  // w_lz[i]: nibbles i..NUM_DIGITS-1 of the shown frame are all zero
  always_comb begin
    logic w_upper_zero;
    w_upper_zero = 1'b1;
    w_lz         = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_upper_zero = w_upper_zero && (r_display[4*i +: 4] == 4'h0);
      w_lz[i]      = w_upper_zero;
    end
  end

  assign w_blank_calc = i_blank_lz && (r_idx != '0) && w_lz[r_idx];

  // blank_lz is only sampled on the first cycle of a slot; on that cycle
  // use the fresh decision so the anode never flashes a suppressed digit.
  assign w_blank_eff = w_slot_start ? w_blank_calc : r_digit_blank;

  always_comb begin
    w_anode_next = {NUM_DIGITS{ANODE_OFF}};
    if (!w_in_guard && !w_blank_eff) begin
      w_anode_next[r_idx] = ANODE_ON;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx         <= '0;
      r_shadow      <= '0;
      r_display     <= '0;
      r_digit_x     <= 4'h0;
      r_digit_blank <= 1'b0;
      r_anode       <= {NUM_DIGITS{ANODE_OFF}};
    end else begin
      r_idx     <= w_idx_next;
      r_shadow  <= w_shadow_next;
      r_display <= w_display_next;
      // Look ahead to the next slot so the nibble is ready on its first cycle
      r_digit_x <= w_display_next[4*int'(w_idx_next) +: 4];
      if (w_slot_start) begin
        r_digit_blank <= w_blank_calc;
      end
      r_anode   <= w_anode_next;
    end
  end

  assign o_digit_x     = r_digit_x;
  assign o_digit_blank = r_digit_blank;
  assign o_anode       = r_anode;
  assign o_digit_idx   = r_idx;
  assign o_frame_done  = w_frame_end;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// tb/tb_ssd_scan_mux.sv - scoreboard bench for ssd_scan_mux

module tb_ssd_scan_mux;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  digit_x;
  logic        digit_blank;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  ssd_scan_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD       (GD),
    .ANODE_LOW   (1)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_data_in     (data_in),
    .i_load        (load),
    .i_blank_lz    (blank_lz),
    .o_digit_x     (digit_x),
    .o_digit_blank (digit_blank),
    .o_anode       (anode),
    .o_digit_idx   (digit_idx),
    .o_frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] x;
    logic [3:0] an;
    logic       bl;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model state (view of the display after each clock edge)
  int          m_p;
  int          m_idx;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;
  logic [3:0]  m_anode;
  logic [3:0]  m_x;
  logic        m_blank;
  logic        cur_blz = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic upper_zero(input logic [15:0] v, input int i);
    for (int k = i; k < ND; k++) begin
      if (v[4*k +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: drive inputs, predict the post-edge outputs, then compare.
  task automatic step(input logic r, input logic ld, input logic [15:0] d);
    exp_t e;
    logic fe;
    rst      = r;
    load     = ld;
    data_in  = d;
    blank_lz = cur_blz;
    if (r) begin
      m_p = 0; m_idx = 0; m_shadow = 16'h0; m_disp = 16'h0;
      m_anode = 4'hf; m_x = 4'h0; m_blank = 1'b0;
    end else begin
      fe = (m_p == RD - 1) && (m_idx == ND - 1);
      if (ld) m_shadow = d;
      if (fe) m_disp = m_shadow;
      if (m_p == 0) m_blank = cur_blz && (m_idx != 0) && upper_zero(m_disp, m_idx);
      m_anode = ((m_p < GD) || m_blank) ? 4'hf : ~(4'b0001 << m_idx);
      if (m_p == RD - 1) begin
        m_p   = 0;
        m_idx = (m_idx + 1) % ND;
      end else begin
        m_p++;
      end
      m_x = m_disp[4*m_idx +: 4];
    end
    e.idx = m_idx[1:0];
    e.x   = m_x;
    e.an  = m_anode;
    e.bl  = m_blank;
    e.fd  = (m_p == RD - 1) && (m_idx == ND - 1);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("digit_idx", {30'd0, digit_idx}, {30'd0, e.idx});
      check_val("digit_x", {28'd0, digit_x}, {28'd0, e.x});
      check_val("anode", {28'd0, anode}, {28'd0, e.an});
      check_val("digit_blank", {31'd0, digit_blank}, {31'd0, e.bl});
      check_val("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
    end
  endtask

  task automatic run_until(input int p, input int idx);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      if (m_p == p && m_idx == idx) found = 1'b1;
      else step(1'b0, 1'b0, 16'h0);
    end
    check_val("run_until", {31'd0, found}, 32'd1);
  endtask

  // Run one full frame from its first cycle and tally lit cycles per anode
  task automatic count_lit(input int e0, input int e1, input int e2, input int e3, input string tag);
    int lit [ND];
    for (int k = 0; k < ND; k++) lit[k] = 0;
    for (int s = 0; s < ND * RD; s++) begin
      step(1'b0, 1'b0, 16'h0);
      for (int k = 0; k < ND; k++) if (anode[k] == 1'b0) lit[k]++;
    end
    check_val({tag, "_d0"}, lit[0], e0);
    check_val({tag, "_d1"}, lit[1], e1);
    check_val({tag, "_d2"}, lit[2], e2);
    check_val({tag, "_d3"}, lit[3], e3);
  endtask

  logic [3:0] x_tbl [ND];
  logic [3:0] an_tbl [ND];
  int         fd_cnt;

  initial begin
    an_tbl[0] = 4'b1110; an_tbl[1] = 4'b1101; an_tbl[2] = 4'b1011; an_tbl[3] = 4'b0111;

    // Reset held three cycles
    repeat (3) step(1'b1, 1'b0, 16'h0);
    check_val("rst_anode", {28'd0, anode}, 32'hf);
    check_val("rst_idx", {30'd0, digit_idx}, 32'd0);
    check_val("rst_digit_x", {28'd0, digit_x}, 32'd0);
    check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);

    // Frame 0 shows zero; 1234 appears from frame 1
    step(1'b0, 1'b1, 16'h1234);
    repeat (ND * RD - 1) step(1'b0, 1'b0, 16'h0);

    // Frame 1: ABCD loaded mid-frame must not tear the 1234 frame
    x_tbl[0] = 4'h4; x_tbl[1] = 4'h3; x_tbl[2] = 4'h2; x_tbl[3] = 4'h1;
    fd_cnt = 0;
    for (int s = 0; s < ND * RD; s++) begin
      step(1'b0, (s == 16), 16'hABCD);
      if (frame_done) fd_cnt++;
      if (m_p == 3) begin
        check_val("f1_digit_x", {28'd0, digit_x}, {28'd0, x_tbl[m_idx]});
        check_val("f1_anode", {28'd0, anode}, {28'd0, an_tbl[m_idx]});
      end
    end
    check_val("fd_per_frame", fd_cnt, 32'd1);

    // Frame 2 shows D,C,B,A
    x_tbl[0] = 4'hd; x_tbl[1] = 4'hc; x_tbl[2] = 4'hb; x_tbl[3] = 4'ha;
    for (int s = 0; s < ND * RD; s++) begin
      step(1'b0, 1'b0, 16'h0);
      if (m_p == 3) check_val("f2_digit_x", {28'd0, digit_x}, {28'd0, x_tbl[m_idx]});
    end

    // Load exactly on the frame-boundary TC: next slot already shows 00F0
    run_until(RD - 1, ND - 1);
    step(1'b0, 1'b1, 16'h00F0);
    check_val("bypass_digit_x", {28'd0, digit_x}, 32'h0);
    repeat (ND * RD) step(1'b0, 1'b0, 16'h0);

    // Leading-zero blanking: 0050 lights digits 0,1 only
    cur_blz = 1'b1;
    step(1'b0, 1'b1, 16'h0050);
    run_until(RD - 1, ND - 1);
    step(1'b0, 1'b0, 16'h0);
    count_lit(6, 6, 0, 0, "lz_0050");

    // Value 0: only digit 0 lit
    step(1'b0, 1'b1, 16'h0000);
    run_until(RD - 1, ND - 1);
    step(1'b0, 1'b0, 16'h0);
    count_lit(6, 0, 0, 0, "lz_0000");

    // Reset in the middle of digit 2's slot discards everything
    cur_blz = 1'b0;
    step(1'b0, 1'b1, 16'h1234);
    run_until(RD - 1, ND - 1);
    step(1'b0, 1'b0, 16'h0);
    run_until(5, 2);
    step(1'b1, 1'b0, 16'h0);
    check_val("midrst_idx", {30'd0, digit_idx}, 32'd0);
    check_val("midrst_anode", {28'd0, anode}, 32'hf);
    check_val("midrst_digit_x", {28'd0, digit_x}, 32'd0);
    repeat (2 * ND * RD) step(1'b0, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
